mem_stage: RTL
==============

Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits between the ex_mem pipeline register and the mem_wb pipeline register.
- Non-memory instructions pass through in the same cycle.
- Loads and stores go through a req/ack data bus, driven by a small FSM. The FSM stalls the pipeline until the access completes.
- Produces the write-back triple mem_wd / mem_wreg / mem_wdata, which mem_wb registers.

Parameters:
- DW, 32, data/register width (`RegBus`); only 32 is supported.
- AW, 5, register address width (`RegAddrBus`).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1).
- ex_wd  in  5  destination register from ex_mem.
- ex_wreg  in  1  register write enable from ex_mem.
- ex_wdata  in  32  ALU result (non-memory ops).
- ex_memop  in  4  memory op: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9..15 treated as none.
- ex_maddr  in  32  effective byte address.
- ex_sdata  in  32  store data (rt value).
- mem_wd  out  5  to mem_wb.
- mem_wreg  out  1  to mem_wb.
- mem_wdata  out  32  to mem_wb.
- stall_req  out  1  freeze PC/if_id/id_ex/ex_mem and bubble mem_wb.
- addr_err  out  1  one-cycle misalignment flag (adel/ades) for the exception unit.
- dbus_req  out  1  bus request (registered).
- dbus_we  out  1  1 = store (registered).
- dbus_addr  out  32  word address, bits[1:0] = 0 (registered).
- dbus_sel  out  4  byte enables; sel[3] = bits 31:24 (registered).
- dbus_wdata  out  32  store data, lane-replicated (registered).
- dbus_ack  in  1  one-cycle completion pulse.
- dbus_rdata  in  32  read data, valid with dbus_ack.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - state <= IDLE; dbus_req, dbus_we, dbus_sel <= 0; dbus_addr, dbus_wdata, rdata buffer <= 0.
  - While rst is high, combinational outputs are forced: mem_wd = `NOPRegAddr`, mem_wreg = `WriteDisable`, mem_wdata = `ZeroWord`, stall_req = 0, addr_err = 0.
  - Reset mid-access drops dbus_req the next edge; the bus must tolerate an abandoned request.
- Endianness: big-endian. addr[1:0] = 0 selects bits 31:24 / sel 4'b1000; halfword at addr[1] = 0 selects bits 31:16 / sel 4'b1100; word uses sel 4'b1111.
- Alignment: LH/LHU/SH require addr[0] = 0; LW/SW require addr[1:0] = 0.
  - A misaligned op causes no bus access, no stall, addr_err = 1 for that cycle, and mem_wreg = 0.
- Non-memory op (state IDLE): mem_wd = ex_wd, mem_wreg = ex_wreg, mem_wdata = ex_wdata, stall_req = 0. Combinational, zero latency.
- FSM states IDLE, BUSY, DONE:
  - IDLE + aligned memory op:
    - stall_req = 1, mem_wreg = 0.
    - At the edge: load dbus_addr = {maddr[31:2], 2'b00}, dbus_sel, dbus_we, and dbus_wdata (SB: byte x4; SH: half x2; SW: word); set dbus_req = 1; go to BUSY.
  - BUSY:
    - stall_req = 1, mem_wreg = 0, dbus_req held at 1 with all bus fields stable.
    - On dbus_ack: capture dbus_rdata, drop dbus_req, go to DONE.
    - An ack-less BUSY waits indefinitely; there is no timeout.
  - DONE:
    - stall_req = 0.
    - Loads: mem_wreg = ex_wreg, mem_wd = ex_wd, mem_wdata = extracted lane, sign-extended for LB/LH and zero-extended for LBU/LHU.
    - Stores: mem_wreg = ex_wreg (0 from decode), mem_wdata = ex_wdata.
    - Next edge: go to IDLE. ex_mem advances on that same edge, so the op is never reissued.
- Latency: memory op occupies ≥3 cycles (IDLE, BUSY×N, DONE); minimum is 3 when ack arrives in the first BUSY cycle.
- dbus_ack in IDLE or DONE is ignored.
- Inputs ex_* are held stable by ex_mem while stall_req = 1; the block does not latch them except as described above.

Test Plan:
- Pass-through: memop = 0, ex_wd = 5'd8, ex_wreg = 1, ex_wdata = 32'h1234_5678 -> same cycle mem_* equal the inputs, stall_req = 0, dbus_req stays 0.
- LB with sign extension: memop = 1, maddr = 32'h0000_1002, ack after 2 BUSY cycles with rdata = 32'h11_22_F3_44 -> dbus_addr = 32'h1000, sel = 4'b0010; stall_req high for 3 cycles; DONE gives mem_wdata = 32'hFFFF_FFF3, mem_wreg = 1.
- LHU / LW: LHU at maddr = 32'h2000, rdata = 32'h8001_7FFF -> mem_wdata = 32'h0000_8001. LW at 32'h2004 -> mem_wdata = rdata exactly, sel = 4'b1111.
- SB store lanes: memop = 6, maddr = 32'h3003, sdata = 32'hDEAD_BEAA -> dbus_we = 1, sel = 4'b0001, dbus_wdata = 32'hAAAA_AAAA; mem_wreg = 0 in DONE.
- Misaligned: LW at 32'h4002 and SH at 32'h4001 -> addr_err = 1 for one cycle, no dbus_req, stall_req = 0, mem_wreg = 0.
- Reset mid-BUSY: assert rst for 1 cycle while dbus_req = 1 -> next edge dbus_req = 0 and state IDLE; a later ack is ignored; outputs are 0 during reset.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Non-memory results pass straight through to mem_wb. Loads and stores run a
// req/ack data-bus transaction sequenced by a three-state FSM, and the stage
// stalls the rest of the pipeline until that transaction completes.
module mem_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ex_wd,
    input  logic          ex_wreg,
    input  logic [DW-1:0] ex_wdata,
    input  logic [3:0]    ex_memop,
    input  logic [DW-1:0] ex_maddr,
    input  logic [DW-1:0] ex_sdata,
    output logic [AW-1:0] mem_wd,
    output logic          mem_wreg,
    output logic [DW-1:0] mem_wdata,
    output logic          stall_req,
    output logic          addr_err,
    output logic          dbus_req,
    output logic          dbus_we,
    output logic [DW-1:0] dbus_addr,
    output logic [3:0]    dbus_sel,
    output logic [DW-1:0] dbus_wdata,
    input  logic          dbus_ack,
    input  logic [DW-1:0] dbus_rdata
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state_q;
    logic          req_q;
    logic          we_q;
    logic [DW-1:0] addr_q;
    logic [3:0]    sel_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;

    logic          is_load;
    logic          is_store;
    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic          misaligned;
    logic [3:0]    sel_d;
    logic [DW-1:0] wdata_d;
    logic [DW-1:0] load_data;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;

    // Decode the memory op into class, access size, alignment and bus lanes (big-endian).
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (ex_memop)
            OP_LB, OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LW:         begin is_load  = 1'b1; is_word = 1'b1; end
            OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
            default:       ;
        endcase

        misaligned = (is_half && ex_maddr[0]) || (is_word && (ex_maddr[1:0] != 2'b00));

        sel_d   = '0;
        wdata_d = ex_sdata;
        if (is_byte) begin
            sel_d   = 4'b1000 >> ex_maddr[1:0];
            wdata_d = {4{ex_sdata[7:0]}};
        end else if (is_half) begin
            sel_d   = ex_maddr[1] ? 4'b0011 : 4'b1100;
            wdata_d = {2{ex_sdata[15:0]}};
        end else if (is_word) begin
            sel_d   = 4'b1111;
        end
    end

    // Pick the addressed lane out of the captured read data and extend it.
    always_comb begin
        case (ex_maddr[1:0])
            2'd0:    lane_b = rdata_q[31:24];
            2'd1:    lane_b = rdata_q[23:16];
            2'd2:    lane_b = rdata_q[15:8];
            default: lane_b = rdata_q[7:0];
        endcase
        lane_h = ex_maddr[1] ? rdata_q[15:0] : rdata_q[31:16];

        case (ex_memop)
            OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_data = {24'd0, lane_b};
            OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_data = {16'd0, lane_h};
            default: load_data = rdata_q;
        endcase
    end

    // Bus FSM: launch the access from IDLE, hold it through BUSY, present the result in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((is_load || is_store) && !misaligned) begin
                        addr_q  <= {ex_maddr[DW-1:2], 2'b00};
                        sel_q   <= sel_d;
                        we_q    <= is_store;
                        wdata_q <= wdata_d;
                        req_q   <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (dbus_ack) begin
                        rdata_q <= dbus_rdata;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Write-back triple, stall and alignment flag, forced quiet while reset is held.
    always_comb begin
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
        stall_req = 1'b0;
        addr_err  = 1'b0;
        if (rst) begin
            mem_wd    = '0;
            mem_wreg  = 1'b0;
            mem_wdata = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_load || is_store) begin
                        mem_wreg = 1'b0;
                        if (misaligned) addr_err  = 1'b1;
                        else            stall_req = 1'b1;
                    end
                end
                BUSY: begin
                    stall_req = 1'b1;
                    mem_wreg  = 1'b0;
                end
                DONE: begin
                    if (is_load) mem_wdata = load_data;
                end
                default: ;
            endcase
        end
    end

    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_sel   = sel_q;
    assign dbus_wdata = wdata_q;

endmodule
